// File: rtl/gcd_controller_if.sv
// Handshake and control bundle between the GCD controller (master) and its datapath/host (slave).
// Carries start/operand intake, comparator flags, load/select strobes and status.
interface gcd_controller_if #(
  parameter int CW = 8
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          gt;
  logic          lt;
  logic          eq;
  logic          ldA;
  logic          ldB;
  logic          sel1;
  logic          sel2;
  logic          sel_in;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] iter_count;

  modport master (
    input  start, in_valid, gt, lt, eq,
    output in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_count
  );

  modport slave (
    output start, in_valid, gt, lt, eq,
    input  in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_count
  );
endinterface

// File: rtl/gcd_controller.sv
// Control FSM for the subtractive GCD datapath; N subtracts finish 3 + N + 1 cycles after start.
// Operand intake stalls indefinitely on in_valid; a watchdog and flag check force ERR instead of hanging.
module gcd_controller #(
  parameter int CW       = 8,
  parameter int MAX_ITER = 255
) (
  input  logic               clk,
  input  logic               rst,
  gcd_controller_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CMP,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CW-1:0] LAST_STEP = CW'(MAX_ITER - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] iter_q, iter_nxt;
  logic          flags_ok;

  assign flags_ok       = $onehot({bus.gt, bus.lt, bus.eq});
  assign bus.iter_count = iter_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      iter_q <= '0;
    end else begin
      state  <= state_nxt;
      iter_q <= iter_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    iter_nxt     = iter_q;
    bus.in_ready = 1'b0;
    bus.ldA      = 1'b0;
    bus.ldB      = 1'b0;
    bus.sel1     = 1'b0;
    bus.sel2     = 1'b0;
    bus.sel_in   = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        bus.done = (state == S_DONE);
        bus.err  = (state == S_ERR);
        if (bus.start) begin
          state_nxt = S_LOAD_A;
          iter_nxt  = '0;
        end
      end

      S_LOAD_A: begin
        bus.in_ready = 1'b1;
        bus.sel_in   = 1'b1;
        bus.busy     = 1'b1;
        if (bus.in_valid) begin
          bus.ldA   = 1'b1;
          state_nxt = S_LOAD_B;
        end
      end

      S_LOAD_B: begin
        bus.in_ready = 1'b1;
        bus.sel_in   = 1'b1;
        bus.busy     = 1'b1;
        if (bus.in_valid) begin
          bus.ldB   = 1'b1;
          state_nxt = S_CMP;
        end
      end

      S_CMP: begin
        bus.busy = 1'b1;
        // A flag set that is not exactly one-hot means the datapath cannot be trusted.
        if (!flags_ok) begin
          state_nxt = S_ERR;
        end else if (bus.eq) begin
          state_nxt = S_DONE;
        end else begin
          if (bus.gt) begin
            bus.sel2 = 1'b1;
            bus.ldA  = 1'b1;
          end else begin
            bus.sel1 = 1'b1;
            bus.ldB  = 1'b1;
          end
          iter_nxt = iter_q + CW'(1);
          if (iter_q == LAST_STEP) begin
            state_nxt = S_ERR;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- Control FSM that drives the 16-bit subtractive GCD datapath: operand load, mux selects and register enables.
- Consumes the datapath comparator flags (gt/lt/eq) and produces ldA, ldB, sel1, sel2, sel_in.
- Adds a start/done protocol, a valid/ready operand intake and an iteration watchdog, so zero operands or a faulty datapath cannot hang the system.

Parameters:
CW, 8, width of the iteration counter.
MAX_ITER, 255, number of subtract steps allowed before the watchdog error; must be ≤ 2^CW − 1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request a new GCD; sampled in IDLE, DONE and ERR.
in_valid  in  1  operand present on datapath data_in.
in_ready  out  1  controller accepting an operand this cycle.
gt  in  1  datapath flag, A > B.
lt  in  1  datapath flag, A < B.
eq  in  1  datapath flag, A == B.
ldA  out  1  load enable, register A.
ldB  out  1  load enable, register B.
sel1  out  1  subtractor X select: 0 = A, 1 = B.
sel2  out  1  subtractor Y select: 0 = A, 1 = B.
sel_in  out  1  bus select: 0 = subtractor output, 1 = data_in.
busy  out  1  operation in progress.
done  out  1  result valid in register A (and B).
err  out  1  watchdog expiry or illegal flag combination.
iter_count  out  CW  subtract steps taken in the current or last operation.

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, CMP, DONE, ERR.
- Encoding is free; the state register and iter_count are the only flops.
- Control outputs are a combinational decode of the state and (in CMP) the flags.
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE, iter_count = 0.
  - All outputs 0: ldA, ldB, sel1, sel2, sel_in, in_ready, busy, done, err.
- IDLE:
  - All outputs 0.
  - start = 1 → LOAD_A, and iter_count cleared to 0.
- LOAD_A:
  - in_ready = 1, sel_in = 1, busy = 1.
  - in_valid = 1 → ldA = 1 the same cycle, next state LOAD_B.
  - Otherwise wait; no timeout.
- LOAD_B:
  - Same as LOAD_A, but asserts ldB and goes to CMP.
  - The first CMP cycle sees flags computed from the newly loaded A and B.
- CMP (busy = 1, sel_in = 0, in_ready = 0). Exactly one flag is expected:
  - eq → no load, next state DONE.
  - gt → sel1 = 0, sel2 = 1, ldA = 1 (A ← A − B); iter_count + 1; stay in CMP.
  - lt → sel1 = 1, sel2 = 0, ldB = 1 (B ← B − A); iter_count + 1; stay in CMP.
  - Zero flags or more than one flag set → no load, next state ERR.
  - A subtract that takes iter_count to MAX_ITER → next state ERR, not CMP. No further loads are issued.
- DONE:
  - done = 1 and held (level, not pulse); busy = 0.
  - iter_count frozen.
  - start = 1 → LOAD_A, iter_count cleared, done drops the next cycle.
- ERR:
  - err = 1 and held; busy = 0; iter_count frozen.
  - start = 1 → LOAD_A, as from DONE.
- start while busy (LOAD_A, LOAD_B, CMP) is ignored.
- in_valid outside LOAD_A/LOAD_B is ignored; in_ready = 0 there.
- Latency: an operation with N subtracts and no input stalls takes 3 + N + 1 cycles, from the start cycle to the first cycle with done = 1.
- Counter arithmetic is unsigned and never wraps; the watchdog guarantees this.

Test Plan:
- Start, then operands 12 and 8 on back-to-back in_valid cycles → ldA@1, ldB@2, ldA@3 (A=4), ldB@4 (B=4), eq@5, done = 1 from cycle 6, iter_count = 2, result A = 4.
- Operands 7 and 7 → zero subtracts, done on the cycle after the first CMP cycle, iter_count = 0, A = 7.
- MAX_ITER = 16, operands 5 and 0 → gt every cycle, 16 ldA pulses, then err = 1, done = 0, iter_count = 16, no further loads.
- in_valid held low 5 cycles in LOAD_B → in_ready stays 1, ldB = 0, state held; the load occurs on the cycle in_valid rises.
- Force gt = lt = 1 in CMP → ERR next cycle, no load; start from ERR → LOAD_A with err cleared and iter_count = 0.
- rst asserted mid-CMP (asynchronous, between clock edges) → all outputs 0 immediately; after release, IDLE ignores flags until start.
